framebuffer_arbiter: RTL

FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

---
 rtl/framebuffer_pkg.sv | 17 +
 rtl/framebuffer_clear.sv | 41 ++++
 rtl/framebuffer_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/framebuffer_pkg.sv
// Shared widths, default geometry and FSM state type for the framebuffer arbiter.
package framebuffer_pkg;

  localparam int FB_ADDR_W        = 17;
  localparam int FB_DATA_W        = 16;
  localparam int FB_WORDS_DEFAULT = 98304;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } FbState;

  function automatic logic addrInRange(input logic [FB_ADDR_W-1:0] address, input int words);
    return 32'(address) < 32'(words);
  endfunction

endpackage

// File: rtl/framebuffer_clear.sv
// Clear sequencer: walks addresses 0..FB_WORDS-1 once per start, holding the sampled colour.
import framebuffer_pkg::*;

module framebuffer_clear #(
  parameter int FB_WORDS = FB_WORDS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [FB_DATA_W-1:0] color,
  output logic                 busy,
  output logic                 lastWrite,
  output logic [FB_ADDR_W-1:0] address,
  output logic [FB_DATA_W-1:0] colorHeld
);

  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FB_WORDS - 1);

  // Start is only raised by the top while idle, so it never restarts a running clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      address   <= '0;
      colorHeld <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      address   <= '0;
      colorHeld <= color;
    end else if (busy) begin
      if (address == LAST_ADDR) begin
        busy    <= 1'b0;
        address <= '0;
      end else begin
        address <= address + 1'b1;
      end
    end
  end

  assign lastWrite = busy && (address == LAST_ADDR);

endmodule

// File: rtl/framebuffer_arbiter.sv
// Two-way round-robin arbiter onto a single framebuffer port.
// Optional clear sequencer enabled by defining FB_CLEAR_EN.
import framebuffer_pkg::*;

module framebuffer_arbiter #(
  parameter int FB_WORDS = FB_WORDS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef FB_CLEAR_EN
  input  logic                 clearStart,
  input  logic [FB_DATA_W-1:0] clearColor,
  output logic                 clearBusy,
`endif
  input  logic                 reqValid0,
  output logic                 reqReady0,
  input  logic                 reqWrite0,
  input  logic [FB_ADDR_W-1:0] reqAddress0,
  input  logic [FB_DATA_W-1:0] reqData0,
  output logic                 respValid0,
  output logic [FB_DATA_W-1:0] respData0,
  input  logic                 reqValid1,
  output logic                 reqReady1,
  input  logic                 reqWrite1,
  input  logic [FB_ADDR_W-1:0] reqAddress1,
  input  logic [FB_DATA_W-1:0] reqData1,
  output logic                 respValid1,
  output logic [FB_DATA_W-1:0] respData1,
  output logic [FB_ADDR_W-1:0] fbAddress,
  output logic [FB_DATA_W-1:0] fbDataIn,
  output logic                 fbWriteEnable,
  input  logic [FB_DATA_W-1:0] fbDataOut
);

  FbState state;
  logic   favourOne;
  logic   pendRead0;
  logic   pendRead1;
  logic   pendOutOfRange;
  logic   clearGo;
  logic   clrBusy;
  logic   clrLast;
  logic [FB_ADDR_W-1:0] clrAddress;
  logic [FB_DATA_W-1:0] clrColor;
  logic   grantAllowed;
  logic   grant0;
  logic   grant1;

`ifdef FB_CLEAR_EN
  assign clearGo   = !reset && (state == IDLE) && clearStart;
  assign clearBusy = clrBusy && !reset;

  framebuffer_clear #(.FB_WORDS(FB_WORDS)) uClear (
    .clk       (clk),
    .reset     (reset),
    .start     (clearGo),
    .color     (clearColor),
    .busy      (clrBusy),
    .lastWrite (clrLast),
    .address   (clrAddress),
    .colorHeld (clrColor)
  );
`else
  assign clearGo    = 1'b0;
  assign clrBusy    = 1'b0;
  assign clrLast    = 1'b0;
  assign clrAddress = '0;
  assign clrColor   = '0;
`endif

  // A clear start steals the cycle from both requesters.
  assign grantAllowed = !reset && (state == IDLE) && !clearGo;
  assign grant0 = grantAllowed && reqValid0 && (!reqValid1 || !favourOne);
  assign grant1 = grantAllowed && reqValid1 && (!reqValid0 ||  favourOne);
  assign reqReady0 = grant0;
  assign reqReady1 = grant1;

  always_comb begin
    fbAddress     = '0;
    fbDataIn      = '0;
    fbWriteEnable = 1'b0;
    if (clrBusy && !reset) begin
      fbAddress     = clrAddress;
      fbDataIn      = clrColor;
      fbWriteEnable = 1'b1;
    end else if (grant0) begin
      fbAddress     = reqAddress0;
      fbDataIn      = reqData0;
      fbWriteEnable = reqWrite0 && addrInRange(reqAddress0, FB_WORDS);
    end else if (grant1) begin
      fbAddress     = reqAddress1;
      fbDataIn      = reqData1;
      fbWriteEnable = reqWrite1 && addrInRange(reqAddress1, FB_WORDS);
    end
  end

  // State, round-robin pointer and pending-read tracking advance together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      favourOne      <= 1'b0;
      pendRead0      <= 1'b0;
      pendRead1      <= 1'b0;
      pendOutOfRange <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (clearGo) state <= CLEAR;
        CLEAR:   if (clrLast) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (grant0)      favourOne <= 1'b1;
      else if (grant1) favourOne <= 1'b0;
      pendRead0      <= grant0 && !reqWrite0;
      pendRead1      <= grant1 && !reqWrite1;
      pendOutOfRange <= !addrInRange(fbAddress, FB_WORDS);
    end
  end

  assign respValid0 = pendRead0 && !reset;
  assign respValid1 = pendRead1 && !reset;
  assign respData0  = (respValid0 && !pendOutOfRange) ? fbDataOut : '0;
  assign respData1  = (respValid1 && !pendOutOfRange) ? fbDataOut : '0;

endmodule
